// File: rtl/key_pio_servicer.sv
// Services a key PIO interrupt: reads and clears edge_capture over Avalon-MM,
// then queues each nonzero key-event bitmap in a small FIFO for a consumer.
module key_pio_servicer #(
  parameter logic [1:0] MASK_INIT  = 2'b11,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        irq,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  output logic        evt_valid,
  output logic [1:0]  evt_data,
  input  logic        evt_ready,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int         AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;
  localparam logic [2:0] S_PUSH    = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [1:0]  cap;
  logic [1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;
  logic        pop;
  logic        push;
  logic        drop;
  logic        unused_rd;

  assign unused_rd = ^pio_readdata[31:2];

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:    state_next = S_IDLE;
      S_IDLE:    if (irq && enable) state_next = S_READ;
      S_READ:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_CLEAR;
      S_CLEAR:   state_next = S_PUSH;
      S_PUSH:    state_next = S_IDLE;
      default:   state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_INIT;
    else          state <= state_next;
  end

  // Bus registers are loaded from the state being entered, so each access
  // is visible on the bus during the cycle its state is active.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= 2'd0;
      pio_writedata  <= 32'd0;
    end else begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      if (state == S_INIT) begin
        pio_chipselect <= 1'b1;
        pio_write_n    <= 1'b0;
        pio_address    <= 2'd2;
        pio_writedata  <= {30'd0, MASK_INIT};
      end else if (state_next == S_READ) begin
        pio_chipselect <= 1'b1;
        pio_address    <= 2'd3;
      end else if (state_next == S_CLEAR) begin
        pio_chipselect <= 1'b1;
        pio_write_n    <= 1'b0;
        pio_address    <= 2'd3;
        pio_writedata  <= {30'd0, pio_readdata[1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                cap <= 2'd0;
    else if (state == S_CAPTURE) cap <= pio_readdata[1:0];
  end

  assign evt_valid = (count != '0);
  assign evt_data  = mem[rd_ptr];
  assign pop       = evt_valid && evt_ready;
  assign push      = (state == S_PUSH) && (cap != 2'd0) && ((count < DEPTH) || pop);
  assign drop      = (state == S_PUSH) && (cap != 2'd0) && (count >= DEPTH) && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as a clear request leaves the flag set.
  always_ff @(posedge clk) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule
